sseg_scan_controller: RTL and testbench

Time-multiplexed driver for the four-digit common-anode seven-segment display. It holds a 16-bit hex value in a shadow/display register pair and scans digits 0→3 continuously, enabling one anode at a time. A blanking gap precedes every digit slot to suppress ghosting. Its `segments`/`anodes` outputs feed the board display pins and the team's segment-decoding checker directly.

---
 rtl/sseg_pkg.sv | 21 ++
 rtl/sseg_hex_encoder.sv | 15 +
 rtl/sseg_scan_controller.sv | 159 +++++++++++++++
 tb/tb_sseg_scan_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan display blocks.
// Segment order is {a,b,c,d,e,f,g}; segments and anodes are active-low.
package sseg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } sseg_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Hex digit to active-low segment pattern, indexed by nibble value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/sseg_hex_encoder.sv
// Combinational nibble to active-low seven-segment encoder.
// Shared by the display blocks so every display uses the same glyph table.
module sseg_hex_encoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  // Table lookup of the glyph for the selected nibble.
  always_comb begin
    segments = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/sseg_scan_controller.sv
// Four-digit common-anode seven-segment scan controller.
// Scans digits 0..3 with a blank gap before each drive slot. A new value is
// staged in a pending register and copied to the display register only at the
// frame wrap, so a frame never mixes old and new digits.
// Optional macro SSEG_LEADING_ZERO_BLANK_EN: suppress leading zero digits
// (digit 0 always shown).
module sseg_scan_controller
  import sseg_pkg::*;
#(
  parameter int C_TICKS_PER_DIGIT = 100000,
  parameter int C_BLANK_TICKS     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  digit_en,
  output logic [6:0]  segments,
  output logic [3:0]  anodes,
  output logic        frame_done
);

  localparam int CNT_MAX = (C_TICKS_PER_DIGIT > C_BLANK_TICKS) ? C_TICKS_PER_DIGIT : C_BLANK_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(C_TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((C_BLANK_TICKS > 0) ? (C_BLANK_TICKS - 1) : 0);
  // With no blank gap the FSM lives in ST_DRIVE permanently.
  localparam sseg_state_t ST_START = (C_BLANK_TICKS > 0) ? ST_BLANK : ST_DRIVE;

  sseg_state_t   state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [1:0]    idx_r, idx_s;
  logic          wrap_s;
  logic [15:0]   disp_r, pending_r;
  logic          pending_valid_r;
  logic [3:0]    nibble_s, lead_mask_s, shown_s, an_s;
  logic [6:0]    enc_s, seg_s;

  sseg_hex_encoder u_enc (
    .nibble   (nibble_s),
    .segments (enc_s)
  );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // Digits above the most significant nonzero digit are treated as disabled.
  assign lead_mask_s = {|disp_r[15:12], |disp_r[15:8], |disp_r[15:4], 1'b1};
`else
  assign lead_mask_s = 4'hF;
`endif

  assign shown_s = digit_en & lead_mask_s;

  // Next-state logic: blank gap, then drive slot, advancing the digit index.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + CW'(1);
    idx_s   = idx_r;
    wrap_s  = 1'b0;
    case (state_r)
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_s = ST_DRIVE;
          cnt_s   = '0;
        end else begin
          state_s = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (cnt_r == DRIVE_LAST) begin
          idx_s   = idx_r + 2'd1;
          cnt_s   = '0;
          wrap_s  = (idx_r == 2'd3);
          state_s = ST_START;
        end else begin
          state_s = ST_DRIVE;
        end
      end
      default: begin
        state_s = ST_START;
        cnt_s   = '0;
        idx_s   = 2'd0;
      end
    endcase
  end

  // Select the display nibble of the digit currently being scanned.
  always_comb begin
    case (idx_r)
      2'd0:    nibble_s = disp_r[3:0];
      2'd1:    nibble_s = disp_r[7:4];
      2'd2:    nibble_s = disp_r[11:8];
      2'd3:    nibble_s = disp_r[15:12];
      default: nibble_s = 4'h0;
    endcase
  end

  // Pin values for the current state; registered below.
  always_comb begin
    seg_s = SEG_BLANK;
    an_s  = AN_OFF;
    if (state_r == ST_DRIVE) begin
      seg_s = enc_s;
      if (shown_s[idx_r]) begin
        an_s = ~(4'b0001 << idx_r);
      end else begin
        an_s = AN_OFF;
      end
    end else begin
      seg_s = SEG_BLANK;
      an_s  = AN_OFF;
    end
  end

  // Scan state, cycle counter and digit index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_START;
      cnt_r   <= '0;
      idx_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
    end
  end

  // Shadow registers: loads go to pending, display updates only at frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_r          <= 16'h0000;
      pending_r       <= 16'h0000;
      pending_valid_r <= 1'b0;
    end else begin
      if (wrap_s && pending_valid_r) begin
        disp_r <= pending_r;
      end
      if (load) begin
        pending_r       <= value;
        pending_valid_r <= 1'b1;
      end else if (wrap_s) begin
        pending_valid_r <= 1'b0;
      end
    end
  end

  // Registered display pins and end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      segments   <= SEG_BLANK;
      anodes     <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      segments   <= seg_s;
      anodes     <= an_s;
      frame_done <= wrap_s;
    end
  end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Self-checking bench for sseg_scan_controller (4 ticks/digit, 2 blank ticks).
// A cycle model predicts every pin value into a queue at each rising edge;
// the falling edge pops and compares. Directed table vectors and sequences
// check glyphs, enables, load timing, frame period and reset.
module tb_sseg_scan_controller;

  localparam int T  = 4;
  localparam int B  = 2;
  localparam int FR = 4 * (T + B);

  localparam logic [6:0] ENC [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_en;
  logic [6:0]  segments;
  logic [3:0]  anodes;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  sseg_scan_controller #(.C_TICKS_PER_DIGIT(T), .C_BLANK_TICKS(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .digit_en   (digit_en),
    .segments   (segments),
    .anodes     (anodes),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_pos  = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  logic        m_pv   = 1'b0;

  function automatic exp_t model_out(input int pos, input logic [15:0] disp, input logic [3:0] en);
    exp_t e;
    int slot;
    int off;
    logic [3:0] mask;
    slot = pos / (T + B);
    off  = pos % (T + B);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    mask = {disp[15:12] != 4'h0, disp[15:8] != 8'h0, disp[15:4] != 12'h0, 1'b1};
`else
    mask = 4'hF;
`endif
    e.fd = (pos == FR - 1);
    if (off < B) begin
      e.seg = 7'h7F;
      e.an  = 4'hF;
    end else begin
      e.seg = ENC[disp[slot*4 +: 4]];
      e.an  = (en[slot] && mask[slot]) ? ~(4'b0001 << slot) : 4'hF;
    end
    return e;
  endfunction

  // Predict the pins produced by this rising edge and advance the model.
  always @(posedge clk) begin
    if (rst) begin
      q.push_back('{seg: 7'h7F, an: 4'hF, fd: 1'b0});
      m_pos  <= 0;
      m_disp <= 16'h0;
      m_pend <= 16'h0;
      m_pv   <= 1'b0;
    end else begin
      q.push_back(model_out(m_pos, m_disp, digit_en));
      m_disp <= (m_pos == FR - 1 && m_pv) ? m_pend : m_disp;
      m_pend <= load ? value : m_pend;
      m_pv   <= load ? 1'b1 : ((m_pos == FR - 1) ? 1'b0 : m_pv);
      m_pos  <= (m_pos + 1) % FR;
    end
  end

  // Scoreboard comparison away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_segments", {9'h0, segments}, {9'h0, e.seg});
      chk("sb_anodes", {12'h0, anodes}, {12'h0, e.an});
      chk("sb_frame_done", {15'h0, frame_done}, {15'h0, e.fd});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 3 * FR);
    if (frame_done !== 1'b1) begin
      chk("frame_done_timeout", {15'h0, frame_done}, 16'h0001);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  en;
    logic [27:0] seg;  // digit d at [7d +: 7]
    logic [15:0] an;   // digit d at [4d +: 4]
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    vecs[0] = '{16'h1234, 4'hF,
                {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100},
                {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[1] = '{16'hABCD, 4'hF,
                {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010},
                {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[2] = '{16'h5678, 4'b0101,
                {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000},
                {4'b1111, 4'b1011, 4'b1111, 4'b1110}};
    vecs[3] = '{16'h9EF0, 4'hF,
                {7'b0000100, 7'b0110000, 7'b0111000, 7'b0000001},
                {4'b0111, 4'b1011, 4'b1101, 4'b1110}};

    rst = 1'b1; load = 1'b0; value = 16'h0; digit_en = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset_anodes", {12'h0, anodes}, 16'h000F);
    chk("reset_segments", {9'h0, segments}, 16'h007F);
    rst = 1'b0;

    // First anode low on the third cycle after release, showing 0.
    repeat (2) @(negedge clk);
    chk("pre_first_anode", {12'h0, anodes}, 16'h000F);
    @(negedge clk);
    chk("first_anode", {12'h0, anodes}, 16'h000E);
    chk("first_segments", {9'h0, segments}, 16'h0001);

    // Table vectors: load, let it reach the display, check every slot.
    for (int i = 0; i < 4; i++) begin
      digit_en = vecs[i].en;
      do_load(vecs[i].value);
      wait_fd();
      wait_fd();
      for (int k = 1; k <= FR - 1; k++) begin
        @(negedge clk);
        if (k % (T + B) == 1) begin
          chk("vec_blank_an", {12'h0, anodes}, 16'h000F);
          chk("vec_blank_seg", {9'h0, segments}, 16'h007F);
        end else if (k % (T + B) == 4) begin
          chk("vec_seg", {9'h0, segments}, {9'h0, vecs[i].seg[7*(k/(T+B)) +: 7]});
          chk("vec_an", {12'h0, anodes}, {12'h0, vecs[i].an[4*(k/(T+B)) +: 4]});
        end
      end
    end

    // Frame period with disabled digits is unchanged.
    digit_en = 4'b0101;
    wait_fd();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 3 * FR);
    chk("frame_period", n[15:0], FR[15:0]);
    digit_en = 4'hF;

    // Mid-frame loads (last wins) and a load in the wrap cycle.
    wait_fd();
    repeat (4) @(negedge clk);
    do_load(16'h1111);
    repeat (2) @(negedge clk);
    do_load(16'h2222);
    // Now 8 negedges past frame_done; drive so it is sampled in the wrap cycle.
    repeat (FR - 1 - 8) @(negedge clk);
    do_load(16'h3333);
    chk("wrap_frame_done", {15'h0, frame_done}, 16'h0001);
    repeat (3) @(negedge clk);
    chk("last_load_wins", {9'h0, segments}, 16'h0012);
    wait_fd();
    repeat (4) @(negedge clk);
    chk("wrap_load_next", {9'h0, segments}, 16'h0006);

    // Reset during digit 2's drive slot.
    wait_fd();
    repeat (15) @(negedge clk);
    chk("pre_rst_anodes", {12'h0, anodes}, 16'h000B);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_anodes", {12'h0, anodes}, 16'h000F);
    chk("rst_segments", {9'h0, segments}, 16'h007F);
    chk("rst_frame_done", {15'h0, frame_done}, 16'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gap", {12'h0, anodes}, 16'h000F);
    @(negedge clk);
    chk("rst_digit0", {12'h0, anodes}, 16'h000E);
    chk("rst_disp_zero", {9'h0, segments}, 16'h0001);

    // Leading-zero values, checked by the model in either build.
    do_load(16'h0042);
    wait_fd();
    wait_fd();
    repeat (FR) @(negedge clk);
    do_load(16'h0000);
    wait_fd();
    wait_fd();
    repeat (FR) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
